// File: rtl/exec_pkg.sv
// Shared constants for the execute stage: ALU function codes, ALUOp
// encodings, recognised R-type opcodes and the ALU-control decode helper.
package exec_pkg;

  localparam int unsigned FUNC_W  = 4;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned OPC_W   = 11;

  // ALU function codes driven to the ALU
  localparam logic [FUNC_W-1:0] ALU_AND     = 4'b0000;
  localparam logic [FUNC_W-1:0] ALU_ORR     = 4'b0001;
  localparam logic [FUNC_W-1:0] ALU_ADD     = 4'b0010;
  localparam logic [FUNC_W-1:0] ALU_SUB     = 4'b0110;
  localparam logic [FUNC_W-1:0] ALU_PASSB   = 4'b0111;
  localparam logic [FUNC_W-1:0] ALU_NOR     = 4'b1100;
  localparam logic [FUNC_W-1:0] ALU_ILLEGAL = 4'b1111;

  // ALUOp encodings from the control unit; bit 1 selects R-type decode
  localparam logic [ALUOP_W-1:0] ALUOP_LDST  = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_CBZ   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;

  // Recognised R-type opcodes (instruction[31:21])
  localparam logic [OPC_W-1:0] OPC_ADD = 11'b10001011000;
  localparam logic [OPC_W-1:0] OPC_SUB = 11'b11001011000;
  localparam logic [OPC_W-1:0] OPC_AND = 11'b10001010000;
  localparam logic [OPC_W-1:0] OPC_ORR = 11'b10101010000;

  // ALU control: map ALUOp/opcode to a function code
  function automatic logic [FUNC_W-1:0] decode_alu_func(
    input logic [ALUOP_W-1:0] alu_op,
    input logic [OPC_W-1:0]   opcode
  );
    logic [FUNC_W-1:0] func;
    func = ALU_ILLEGAL;
    if (alu_op[1]) begin
      case (opcode)
        OPC_ADD: func = ALU_ADD;
        OPC_SUB: func = ALU_SUB;
        OPC_AND: func = ALU_AND;
        OPC_ORR: func = ALU_ORR;
        default: func = ALU_ILLEGAL;
      endcase
    end else if (alu_op[0]) begin
      func = ALU_PASSB;
    end else begin
      func = ALU_ADD;
    end
    return func;
  endfunction

endpackage

// File: rtl/exec_adder64.sv
// Plain WIDTH-bit ripple-style adder with carry in/out.
// Ports: a, b (WIDTH) operands; cin carry-in; s (WIDTH) sum; cout carry-out.
module exec_adder64 #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH:0] sum_c;

  // One extra bit captures the carry-out
  always_comb begin
    sum_c = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
  end

  assign s    = sum_c[WIDTH-1:0];
  assign cout = sum_c[WIDTH];

endmodule

// File: rtl/alu_exec_unit.sv
// Registered execute stage: ALU-control decode, ALU with flags, PC+4 and
// branch-target adders. All outputs are registered, one cycle of latency.
// Ports:
//   clk, reset_n (async active-low)
//   in_valid, opcode, alu_op, operand_a, operand_b, pc, ext_imm : inputs
//   out_valid, alu_func, result, zero, carry, overflow, illegal,
//   pc_plus4, branch_target : registered outputs
module alu_exec_unit
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  input  logic [WIDTH-1:0]   pc,
  input  logic [WIDTH-1:0]   ext_imm,
  output logic               out_valid,
  output logic [FUNC_W-1:0]  alu_func,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               carry,
  output logic               overflow,
  output logic               illegal,
  output logic [WIDTH-1:0]   pc_plus4,
  output logic [WIDTH-1:0]   branch_target
);

  // ---------------- combinational datapath ----------------
  logic [FUNC_W-1:0] alu_func_c;
  logic              illegal_c;
  logic              is_sub_c;
  logic [WIDTH-1:0]  add_b_c;
  logic [WIDTH-1:0]  add_s_c;
  logic              add_cout_c;
  logic [WIDTH-1:0]  result_c;
  logic              carry_c;
  logic              overflow_c;
  logic              zero_c;
  logic [WIDTH-1:0]  pc_plus4_c;
  logic [WIDTH-1:0]  branch_target_c;
  logic              pc4_cout_unused;
  logic              bt_cout_unused;
  logic              adder_ovf_c;

  always_comb begin
    alu_func_c = decode_alu_func(alu_op, opcode);
    illegal_c  = (alu_func_c == ALU_ILLEGAL);
    is_sub_c   = (alu_func_c == ALU_SUB);
    // Subtract as A + ~B + 1 so carry-out means "no borrow"
    add_b_c    = is_sub_c ? ~operand_b : operand_b;
  end

  exec_adder64 #(.WIDTH(WIDTH)) u_alu_add (
    .a    (operand_a),
    .b    (add_b_c),
    .cin  (is_sub_c),
    .s    (add_s_c),
    .cout (add_cout_c)
  );

  exec_adder64 #(.WIDTH(WIDTH)) u_pc4_add (
    .a    (pc),
    .b    (WIDTH'(4)),
    .cin  (1'b0),
    .s    (pc_plus4_c),
    .cout (pc4_cout_unused)
  );

  // Offset is in words; the shift drops the top two immediate bits
  exec_adder64 #(.WIDTH(WIDTH)) u_bt_add (
    .a    (pc),
    .b    (ext_imm << 2),
    .cin  (1'b0),
    .s    (branch_target_c),
    .cout (bt_cout_unused)
  );

  // Signed overflow: operands agree in sign but the sum does not
  always_comb begin
    adder_ovf_c = (operand_a[WIDTH-1] == add_b_c[WIDTH-1]) &&
                  (add_s_c[WIDTH-1] != operand_a[WIDTH-1]);
  end

  // ALU function select; flags only meaningful for add/sub
  always_comb begin
    result_c   = '0;
    carry_c    = 1'b0;
    overflow_c = 1'b0;
    case (alu_func_c)
      ALU_AND:   result_c = operand_a & operand_b;
      ALU_ORR:   result_c = operand_a | operand_b;
      ALU_ADD, ALU_SUB: begin
        result_c   = add_s_c;
        carry_c    = add_cout_c;
        overflow_c = adder_ovf_c;
      end
      ALU_PASSB: result_c = operand_b;
      ALU_NOR:   result_c = ~(operand_a | operand_b);
      default:   result_c = '0;
    endcase
    zero_c = (result_c == '0);
  end

  // ---------------- output registers ----------------
  logic              out_valid_q,     out_valid_d;
  logic [FUNC_W-1:0] alu_func_q,      alu_func_d;
  logic [WIDTH-1:0]  result_q,        result_d;
  logic              zero_q,          zero_d;
  logic              carry_q,         carry_d;
  logic              overflow_q,      overflow_d;
  logic              illegal_q,       illegal_d;
  logic [WIDTH-1:0]  pc_plus4_q,      pc_plus4_d;
  logic [WIDTH-1:0]  branch_target_q, branch_target_d;

  // Data outputs hold when no valid input is presented
  always_comb begin
    out_valid_d     = in_valid;
    alu_func_d      = alu_func_q;
    result_d        = result_q;
    zero_d          = zero_q;
    carry_d         = carry_q;
    overflow_d      = overflow_q;
    illegal_d       = illegal_q;
    pc_plus4_d      = pc_plus4_q;
    branch_target_d = branch_target_q;
    if (in_valid) begin
      alu_func_d      = alu_func_c;
      result_d        = result_c;
      zero_d          = zero_c;
      carry_d         = carry_c;
      overflow_d      = overflow_c;
      illegal_d       = illegal_c;
      pc_plus4_d      = pc_plus4_c;
      branch_target_d = branch_target_c;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q     <= 1'b0;
      alu_func_q      <= '0;
      result_q        <= '0;
      zero_q          <= 1'b0;
      carry_q         <= 1'b0;
      overflow_q      <= 1'b0;
      illegal_q       <= 1'b0;
      pc_plus4_q      <= '0;
      branch_target_q <= '0;
    end else begin
      out_valid_q     <= out_valid_d;
      alu_func_q      <= alu_func_d;
      result_q        <= result_d;
      zero_q          <= zero_d;
      carry_q         <= carry_d;
      overflow_q      <= overflow_d;
      illegal_q       <= illegal_d;
      pc_plus4_q      <= pc_plus4_d;
      branch_target_q <= branch_target_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign alu_func      = alu_func_q;
  assign result        = result_q;
  assign zero          = zero_q;
  assign carry         = carry_q;
  assign overflow      = overflow_q;
  assign illegal       = illegal_q;
  assign pc_plus4      = pc_plus4_q;
  assign branch_target = branch_target_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: a reference model pushes expected
// outputs into a queue as stimulus is driven; they are popped and compared
// one cycle later when the registered outputs appear.
module tb_alu_exec_unit;

  localparam int unsigned W = 64;

  typedef struct packed {
    logic         valid;
    logic [3:0]   func;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         ovf;
    logic         illegal;
    logic [W-1:0] pc4;
    logic [W-1:0] bt;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [10:0]  opcode = '0;
  logic [1:0]   alu_op = '0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic [W-1:0] pc = '0;
  logic [W-1:0] ext_imm = '0;
  logic         out_valid;
  logic [3:0]   alu_func;
  logic [W-1:0] result;
  logic         zero;
  logic         carry;
  logic         overflow;
  logic         illegal;
  logic [W-1:0] pc_plus4;
  logic [W-1:0] branch_target;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];
  exp_t last_exp = '0;

  localparam logic [10:0] O_ADD = 11'b10001011000;
  localparam logic [10:0] O_SUB = 11'b11001011000;
  localparam logic [10:0] O_AND = 11'b10001010000;
  localparam logic [10:0] O_ORR = 11'b10101010000;
  localparam logic [10:0] O_BAD = 11'b11111111111;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .opcode        (opcode),
    .alu_op        (alu_op),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .pc            (pc),
    .ext_imm       (ext_imm),
    .out_valid     (out_valid),
    .alu_func      (alu_func),
    .result        (result),
    .zero          (zero),
    .carry         (carry),
    .overflow      (overflow),
    .illegal       (illegal),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model of one captured cycle
  function automatic exp_t model(input logic iv, input logic [1:0] op, input logic [10:0] opc,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] p, input logic [W-1:0] imm);
    exp_t e;
    logic [W:0] wide;
    if (!iv) begin
      e = last_exp;
      e.valid = 1'b0;
      return e;
    end
    e = '0;
    e.valid = 1'b1;
    if (op == 2'b00)      e.func = 4'b0010;
    else if (op == 2'b01) e.func = 4'b0111;
    else if (opc == O_ADD) e.func = 4'b0010;
    else if (opc == O_SUB) e.func = 4'b0110;
    else if (opc == O_AND) e.func = 4'b0000;
    else if (opc == O_ORR) e.func = 4'b0001;
    else begin
      e.func = 4'b1111;
      e.illegal = 1'b1;
    end
    case (e.func)
      4'b0000: e.result = a & b;
      4'b0001: e.result = a | b;
      4'b0010: begin
        wide = {1'b0, a} + {1'b0, b};
        e.result = wide[W-1:0];
        e.carry = wide[W];
        e.ovf = (a[W-1] == b[W-1]) && (e.result[W-1] != a[W-1]);
      end
      4'b0110: begin
        e.result = a - b;
        e.carry = (a >= b);
        e.ovf = (a[W-1] != b[W-1]) && (e.result[W-1] != a[W-1]);
      end
      4'b0111: e.result = b;
      default: e.result = '0;
    endcase
    e.zero = (e.result == '0);
    e.pc4 = p + 64'd4;
    e.bt = p + {imm[W-3:0], 2'b00};
    return e;
  endfunction

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_valid"},   W'(out_valid), W'(e.valid));
    chk({tag, "_func"},    W'(alu_func),  W'(e.func));
    chk({tag, "_result"},  result,        e.result);
    chk({tag, "_zero"},    W'(zero),      W'(e.zero));
    chk({tag, "_carry"},   W'(carry),     W'(e.carry));
    chk({tag, "_ovf"},     W'(overflow),  W'(e.ovf));
    chk({tag, "_illegal"}, W'(illegal),   W'(e.illegal));
    chk({tag, "_pc4"},     pc_plus4,      e.pc4);
    chk({tag, "_bt"},      branch_target, e.bt);
  endtask

  // Called at a negedge: drive, push expectation, compare after next posedge
  task automatic cycle(input string tag, input logic iv, input logic [1:0] op,
                       input logic [10:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] p, input logic [W-1:0] imm);
    exp_t e;
    in_valid = iv; alu_op = op; opcode = opc;
    operand_a = a; operand_b = b; pc = p; ext_imm = imm;
    e = model(iv, op, opc, a, b, p, imm);
    last_exp = e;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare_out(tag);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"},   W'(out_valid), '0);
    chk({tag, "_func"},    W'(alu_func),  '0);
    chk({tag, "_result"},  result,        '0);
    chk({tag, "_zero"},    W'(zero),      '0);
    chk({tag, "_carry"},   W'(carry),     '0);
    chk({tag, "_ovf"},     W'(overflow),  '0);
    chk({tag, "_illegal"}, W'(illegal),   '0);
    chk({tag, "_pc4"},     pc_plus4,      '0);
    chk({tag, "_bt"},      branch_target, '0);
  endtask

  initial begin
    logic [10:0] opcs [5];
    opcs[0] = O_ADD; opcs[1] = O_SUB; opcs[2] = O_AND; opcs[3] = O_ORR; opcs[4] = O_BAD;

    #3;
    check_all_zero("por");
    @(negedge clk);
    reset_n = 1'b1;

    cycle("add_ld", 1'b1, 2'b00, 11'd0, 64'h10, 64'h8, 64'h200, 64'h1);
    chk("add_ld_literal", result, 64'h18);
    cycle("hold", 1'b0, 2'b10, O_SUB, 64'h1, 64'h2, 64'h0, 64'h0);
    chk("hold_literal", result, 64'h18);
    cycle("sub_eq", 1'b1, 2'b10, O_SUB, 64'd5, 64'd5, 64'h0, 64'h0);
    cycle("and", 1'b1, 2'b10, O_AND, 64'hF0F0, 64'h0FF0, 64'h40, 64'h3);
    chk("and_literal", result, 64'h00F0);
    cycle("orr", 1'b1, 2'b11, O_ORR, 64'hF0F0, 64'h0FF0, 64'h40, 64'h3);
    chk("orr_literal", result, 64'hFFF0);
    cycle("illegal", 1'b1, 2'b10, O_BAD, 64'hF0F0, 64'h0FF0, 64'h40, 64'h3);
    cycle("cbz", 1'b1, 2'b01, 11'd0, 64'h1234, 64'h0, 64'h100, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("cbz_bt_literal", branch_target, 64'hF8);
    cycle("add_ovf", 1'b1, 2'b10, O_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 64'h0);
    cycle("add_cry", 1'b1, 2'b10, O_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_FFFF_FFFC, 64'h4000_0000_0000_0001);
    cycle("sub_brw", 1'b1, 2'b10, O_SUB, 64'd3, 64'd7, 64'h8, 64'h0);
    cycle("sub_ovf", 1'b1, 2'b10, O_SUB, 64'h8000_0000_0000_0000, 64'h1, 64'h8, 64'h0);

    // Asynchronous reset mid-cycle while valid traffic is presented
    in_valid = 1'b1; alu_op = 2'b00; operand_a = 64'h55; operand_b = 64'h1;
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    #1;
    reset_n = 1'b1;
    last_exp = '0;
    cycle("post_rst", 1'b1, 2'b00, 11'd0, 64'h21, 64'h21, 64'h30, 64'h2);

    for (int i = 0; i < 40; i++) begin
      cycle("rand", ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            opcs[$urandom_range(0, 4)], {$urandom, $urandom}, {$urandom, $urandom},
            {$urandom, $urandom}, {$urandom, $urandom});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Registered execute-stage datapath of the single-cycle LEGv8-style CPU: ALU-function decode, 64-bit ALU with flags, PC+4 adder and branch-target adder (pc + imm<<2).
- Sits between register-bank/sign-extend outputs and the data memory / branch mux.
- All outputs register on clk with one-cycle latency.

Parameters:
- WIDTH, 64, datapath width for operands, pc and results.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  capture qualifier for this cycle's inputs
- opcode  in  11  instruction[31:21]
- alu_op  in  2  ALUOperation from the control unit
- operand_a  in  WIDTH  read_data_1
- operand_b  in  WIDTH  ALUSrc-mux output
- pc  in  WIDTH  current PC
- ext_imm  in  WIDTH  sign-extended immediate/offset
- out_valid  out  1  registered in_valid
- alu_func  out  4  decoded ALU function
- result  out  WIDTH  ALU result
- zero  out  1  result == 0
- carry  out  1  adder carry-out (add/sub only, else 0)
- overflow  out  1  signed overflow (add/sub only, else 0)
- illegal  out  1  unrecognised R-type opcode
- pc_plus4  out  WIDTH  pc + 4
- branch_target  out  WIDTH  pc + (ext_imm << 2), modulo 2^WIDTH

Behaviour:
- reset_n low forces all outputs to 0 immediately, independent of clk. This includes out_valid, zero, illegal and alu_func = 0000. First capture occurs on the first clk edge after release.
- Rising clk with in_valid=1: all outputs load from this cycle's inputs; latency is 1 cycle.
- in_valid=0: out_valid <= 0; data outputs hold their previous values.
- ALU control decode (combinational):
  - alu_op=00 -> 0010 (add, load/store address).
  - alu_op=01 -> 0111 (pass B, CBZ).
  - alu_op[1]=1 (10 and 11 identical) -> decode opcode:
    - 10001011000 ADD -> 0010
    - 11001011000 SUB -> 0110
    - 10001010000 AND -> 0000
    - 10101010000 ORR -> 0001
    - any other opcode -> 1111, illegal=1.
- ALU functions:
  - 0000 A&B; 0001 A|B; 0010 A+B; 0110 A-B; 0111 B; 1100 ~(A|B).
  - Any other code: result 0 (so zero=1), carry=0, overflow=0.
- Add is A+B with Cin=0. Sub is A+~B with Cin=1, so carry=1 means no borrow.
- Overflow: set when the operand signs match and the result sign differs. For sub, the comparison uses ~B.
- zero is computed from the final result for every function.
- pc_plus4 and branch_target wrap silently with no flags; ext_imm<<2 drops its top 2 bits.
- No internal state beyond the output registers; no handshake backpressure.

Decomposition:
- Shared package exec_pkg holds:
  - ALU function codes (ALU_AND, ALU_ORR, ALU_ADD, ALU_SUB, ALU_PASSB, ALU_NOR, ALU_ILLEGAL).
  - ALUOp encodings.
  - The four R-type opcode constants.
- One sub-module: exec_adder64 (A, B, Cin -> S, Cout), a WIDTH-bit adder instantiated three times (ALU add/sub, PC+4, branch target).
- Decode and logic ops stay inline.

Test Plan:
- Reset: drive valid traffic, assert reset_n=0 between clk edges -> all outputs 0 immediately. After release, first valid input appears one edge later.
- alu_op=00, A=0x10, B=0x8 -> next cycle: result=0x18, alu_func=0010, zero=0, carry=0, out_valid=1. The following cycle with in_valid=0 -> out_valid=0, result holds 0x18.
- alu_op=10, opcode=11001011000, A=5, B=5 -> result=0, zero=1, carry=1, overflow=0, alu_func=0110.
- alu_op=10, A=0xF0F0, B=0x0FF0: AND opcode -> 0x00F0; ORR opcode -> 0xFFF0. Opcode 11111111111 -> illegal=1, alu_func=1111, result=0, zero=1.
- alu_op=01, B=0, pc=0x100, ext_imm=0xFFFF_FFFF_FFFF_FFFE -> zero=1, pc_plus4=0x104, branch_target=0xF8.
- ADD with A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> result=0x8000_0000_0000_0000, overflow=1, carry=0. ADD with A=B=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE, carry=1, overflow=0.
